// File: rtl/can_frame_tx.sv
// can_frame_tx: CAN 2.0A data-frame transmitter with bit stuffing, CRC-15 and ACK check.
// Define CAN_TX_ARB_EN to enable arbitration-loss detection during ID and RTR.
module can_frame_tx #(
    parameter int IFS_BITS = 3
) (
    input  logic        SP,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] ID,
    input  logic [3:0]  DLC,
    input  logic [63:0] DATA,
    input  logic        RX,
    output logic        TX,
    output logic        busy,
    output logic        done,
    output logic        arb_lost,
    output logic        ack_error
);
    typedef enum logic [3:0] {
        S_IDLE, S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA,
        S_CRC, S_CRC_D, S_ACK, S_ACK_D, S_EOF, S_IFS
    } state_t;
    localparam logic [7:0] IFS_LAST = 8'(IFS_BITS - 1);
    state_t      state_q, state_d, adv_st;
    logic [7:0]  cnt_q, cnt_d, adv_cnt, fld_last, data_last;
    logic [81:0] sh_q, sh_d;
    logic [14:0] crc_q, crc_d;
    logic [3:0]  dlc_q, dlc_d, n_bytes;
    logic [2:0]  run_q, run_d;
    logic        tx_q, tx_d, busy_q, busy_d, done_q, done_d, arb_q, arb_d;
    logic        ack_err_q, ack_err_d, ack_seen_q, ack_seen_d;
    logic        fld_end, nb, arb_hit, in_stuff;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        return {c[13:0], 1'b0} ^ ((b ^ c[14]) ? 15'h4599 : 15'h0000);
    endfunction

`ifdef CAN_TX_ARB_EN
    assign arb_hit = (state_q == S_ID || state_q == S_RTR) && tx_q && !RX;
`else
    assign arb_hit = 1'b0;
`endif

    // state_q/cnt_q name the last regular bit sent; a stuff bit on TX leaves them untouched
    always_comb begin
        n_bytes   = dlc_q[3] ? 4'd8 : dlc_q;
        data_last = {1'b0, n_bytes, 3'b000} - 8'd1;
        fld_last  = state_q == S_ID   ? 8'd10 :
                    state_q == S_DLC  ? 8'd3 :
                    state_q == S_DATA ? data_last :
                    state_q == S_CRC  ? 8'd14 :
                    state_q == S_EOF  ? 8'd6 :
                    state_q == S_IFS  ? IFS_LAST : 8'd0;
        fld_end   = cnt_q == fld_last;
        adv_st    = !fld_end ? state_q :
                    state_q == S_IFS ? S_IDLE :
                    (state_q == S_DLC && n_bytes == 4'd0) ? S_CRC : state_t'(state_q + 4'd1);
        adv_cnt   = fld_end ? 8'd0 : cnt_q + 8'd1;
        nb        = (adv_st >= S_ID && adv_st <= S_DATA) ? sh_q[81] :
                    adv_st == S_CRC ? crc_q[14] : 1'b1;
        in_stuff  = state_q >= S_SOF && state_q <= S_CRC;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        run_d      = run_q;
        crc_d      = crc_q;
        sh_d       = sh_q;
        dlc_d      = dlc_q;
        ack_seen_d = ack_seen_q;
        done_d     = 1'b0;
        arb_d      = 1'b0;
        ack_err_d  = 1'b0;
        if (state_q == S_IDLE) begin
            tx_d = 1'b1;
            if (start) begin
                state_d    = S_SOF;
                cnt_d      = 8'd0;
                tx_d       = 1'b0;
                run_d      = 3'd1;
                crc_d      = 15'd0;
                sh_d       = {ID, 3'b000, DLC, DATA};
                dlc_d      = DLC;
                ack_seen_d = 1'b0;
            end
        end else if (arb_hit) begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            arb_d   = 1'b1;
        end else if (in_stuff && run_q == 3'd5) begin
            tx_d  = ~tx_q;
            run_d = 3'd1;
        end else begin
            state_d    = adv_st;
            cnt_d      = adv_cnt;
            tx_d       = nb;
            run_d      = (nb == tx_q) ? run_q + 3'd1 : 3'd1;
            sh_d       = (adv_st >= S_ID && adv_st <= S_DATA) ? sh_q << 1 : sh_q;
            crc_d      = (adv_st >= S_ID && adv_st <= S_DATA) ? crc_step(crc_q, nb) :
                         adv_st == S_CRC ? crc_q << 1 : crc_q;
            ack_err_d  = state_q == S_ACK && RX;
            ack_seen_d = ack_seen_q | ack_err_d;
            done_d     = state_q == S_EOF && fld_end && !ack_seen_q;
        end
        busy_d = state_d != S_IDLE;
    end

    always_ff @(posedge SP) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            tx_q       <= 1'b1;
            run_q      <= 3'd0;
            crc_q      <= 15'd0;
            sh_q       <= '0;
            dlc_q      <= 4'd0;
            ack_seen_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            arb_q      <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            run_q      <= run_d;
            crc_q      <= crc_d;
            sh_q       <= sh_d;
            dlc_q      <= dlc_d;
            ack_seen_q <= ack_seen_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            arb_q      <= arb_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign TX        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign arb_lost  = arb_q;
    assign ack_error = ack_err_q;
endmodule
